// File: rtl/touch_pad_filter_pkg.sv
// Shared types for the Fomu touch pad conditioner: FSM state encodings and a counter width helper.
// Optional feature macro: TOUCH_PAD_LONG_PRESS_EN (long-press detection).
package touch_pad_filter_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } padState_e;

   // Counters run 0..n-1, so ceil(log2(n)) bits, with a floor of one bit.
   function automatic int cntWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/touch_pad_filter_chan.sv
// One touch pad channel: synchroniser, debounce FSM, registered level/pulses/toggle.
// Long-press hold counter is present only when TOUCH_PAD_LONG_PRESS_EN is defined.
module touch_pad_chan
   import touch_pad_filter_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 48000
`ifdef TOUCH_PAD_LONG_PRESS_EN
   ,
   parameter int LONG_CYCLES     = 24000000
`endif
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pad_raw_n_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic toggle_o,
   output logic long_o
);

   localparam int CntW = cntWidth(DEBOUNCE_CYCLES);
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   padState_e              state_q, state_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   press_q, press_d;
   logic                   release_q, release_d;
   logic                   toggle_q, toggle_d;
   logic                   padPressed;
   logic                   longFire;

   // The pad idles high through its pull-up, so the synchroniser resets to "released".
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pad_raw_n_i};
      end
   end

   assign padPressed = ~sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         toggle_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         toggle_q  <= toggle_d;
      end
   end

   // A WAIT state is left early whenever the input flips back, so a bounce never reaches the outputs.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      toggle_d  = toggle_q;
      case (state_q)
         IDLE: begin
            if (padPressed) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!padPressed) begin
               state_d = IDLE;
            end else if (cnt_q == CntMax) begin
               state_d  = PRESSED;
               press_d  = 1'b1;
               level_d  = 1'b1;
               toggle_d = ~toggle_q;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         PRESSED: begin
            if (!padPressed) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (padPressed) begin
               state_d = PRESSED;
            end else if (cnt_q == CntMax) begin
               state_d   = IDLE;
               release_d = 1'b1;
               level_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      if (longFire) begin
         toggle_d = 1'b0;
      end
   end

`ifdef TOUCH_PAD_LONG_PRESS_EN
   localparam int HoldW = cntWidth(LONG_CYCLES);
   localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_CYCLES - 1);

   logic [HoldW-1:0] hold_q, hold_d;
   logic             longFired_q, longFired_d;
   logic             long_q, long_d;

   assign longFire = (state_q == PRESSED) && !longFired_q && (hold_q == HoldMax);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q      <= '0;
         longFired_q <= 1'b0;
         long_q      <= 1'b0;
      end else begin
         hold_q      <= hold_d;
         longFired_q <= longFired_d;
         long_q      <= long_d;
      end
   end

   // The fired flag survives release bounces and is only rearmed once the pad is fully idle again.
   always_comb begin
      hold_d      = hold_q;
      longFired_d = longFired_q;
      long_d      = longFire;
      if ((state_d == PRESSED) && (state_q != PRESSED)) begin
         hold_d = '0;
      end else if ((state_q == PRESSED) && !longFired_q && !longFire) begin
         hold_d = hold_q + HoldW'(1);
      end
      if (longFire) begin
         longFired_d = 1'b1;
      end
      if ((state_d == IDLE) && (state_q != IDLE)) begin
         longFired_d = 1'b0;
      end
   end

   assign long_o = long_q;
`else
   assign longFire = 1'b0;
   assign long_o   = 1'b0;
`endif

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign toggle_o  = toggle_q;

endmodule

// File: rtl/touch_pad_filter.sv
// Fomu touch pad conditioner: NPADS independent debounced channels feeding the RGB driver.
// Define TOUCH_PAD_LONG_PRESS_EN to enable the pad_long pulse; otherwise pad_long is tied low.
module touch_pad_filter
   import touch_pad_filter_pkg::*;
#(
   parameter int NPADS           = 2,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 48000,
   parameter int LONG_CYCLES     = 24000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NPADS-1:0] pad_raw_n,
   output logic [NPADS-1:0] pad_level,
   output logic [NPADS-1:0] pad_press,
   output logic [NPADS-1:0] pad_release,
   output logic [NPADS-1:0] pad_toggle,
   output logic [NPADS-1:0] pad_long
);

   // Reject configurations the channel logic cannot represent.
   if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : gBadParam
      $error("touch_pad_filter: SYNC_STAGES, DEBOUNCE_CYCLES and LONG_CYCLES must all be >= 2");
   end

   for (genvar i = 0; i < NPADS; i++) begin : gChan
      touch_pad_chan #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef TOUCH_PAD_LONG_PRESS_EN
         ,
         .LONG_CYCLES     (LONG_CYCLES)
`endif
      ) uChan (
         .clk         (clk),
         .rst_n       (rst_n),
         .pad_raw_n_i (pad_raw_n[i]),
         .level_o     (pad_level[i]),
         .press_o     (pad_press[i]),
         .release_o   (pad_release[i]),
         .toggle_o    (pad_toggle[i]),
         .long_o      (pad_long[i])
      );
   end

endmodule

// File: tb/tb_touch_pad_filter.sv
// Self-checking bench for touch_pad_filter: directed scenarios plus random pad activity
// against a run-length reference model. Honours TOUCH_PAD_LONG_PRESS_EN if defined.
module tb_touch_pad_filter;

   localparam int NPADS = 2;
   localparam int SYNC  = 2;
   localparam int DEB   = 4;
   localparam int LONG  = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NPADS-1:0] pad_raw_n = '1;
   logic [NPADS-1:0] pad_level, pad_press, pad_release, pad_toggle, pad_long;

   int compared = 0;
   int mismatched = 0;

   touch_pad_filter #(
      .NPADS           (NPADS),
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DEB),
      .LONG_CYCLES     (LONG)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pad_raw_n   (pad_raw_n),
      .pad_level   (pad_level),
      .pad_press   (pad_press),
      .pad_release (pad_release),
      .pad_toggle  (pad_toggle),
      .pad_long    (pad_long)
   );

   always #5 clk = ~clk;

   // Reference model: a level flips once DEB+1 consecutive synchronised samples disagree with it.
   logic [SYNC-1:0]  mSync [NPADS] = '{default: '1};
   int               mRun  [NPADS] = '{default: 0};
   logic [NPADS-1:0] expLevel = '0, expPress = '0, expRelease = '0, expToggle = '0, expLong = '0;
   bit               sPressed;
`ifdef TOUCH_PAD_LONG_PRESS_EN
   int               mHold  [NPADS] = '{default: 0};
   bit               mFired [NPADS] = '{default: 1'b0};
`endif

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p < NPADS; p++) begin
            mSync[p] = '1;
            mRun[p]  = 0;
`ifdef TOUCH_PAD_LONG_PRESS_EN
            mHold[p]  = 0;
            mFired[p] = 1'b0;
`endif
         end
         expLevel = '0; expPress = '0; expRelease = '0; expToggle = '0; expLong = '0;
      end else begin
         expPress = '0; expRelease = '0; expLong = '0;
         for (int p = 0; p < NPADS; p++) begin
            sPressed = !mSync[p][SYNC-1];
            mSync[p] = {mSync[p][SYNC-2:0], pad_raw_n[p]};
`ifdef TOUCH_PAD_LONG_PRESS_EN
            if (expLevel[p] && mRun[p] == 0 && !mFired[p]) begin
               if (mHold[p] == LONG - 1) begin
                  expLong[p]   = 1'b1;
                  expToggle[p] = 1'b0;
                  mFired[p]    = 1'b1;
               end else begin
                  mHold[p]++;
               end
            end
`endif
            if (sPressed != expLevel[p]) begin
               mRun[p]++;
            end else begin
`ifdef TOUCH_PAD_LONG_PRESS_EN
               if (expLevel[p] && mRun[p] != 0) mHold[p] = 0;
`endif
               mRun[p] = 0;
            end
            if (mRun[p] == DEB + 1) begin
               mRun[p]     = 0;
               expLevel[p] = ~expLevel[p];
               if (expLevel[p]) begin
                  expPress[p]  = 1'b1;
                  expToggle[p] = ~expToggle[p];
`ifdef TOUCH_PAD_LONG_PRESS_EN
                  mHold[p] = 0;
`endif
               end else begin
                  expRelease[p] = 1'b1;
`ifdef TOUCH_PAD_LONG_PRESS_EN
                  mFired[p] = 1'b0;
`endif
               end
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [NPADS-1:0] actual,
                              input logic [NPADS-1:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %b, want %b at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle of raw pad values, then compare every output against the model.
   task automatic applyStimulus(input logic [NPADS-1:0] raw);
      pad_raw_n = raw;
      @(posedge clk);
      #1;
      checkOutput("level",   pad_level,   expLevel);
      checkOutput("press",   pad_press,   expPress);
      checkOutput("release", pad_release, expRelease);
      checkOutput("toggle",  pad_toggle,  expToggle);
      checkOutput("long",    pad_long,    expLong);
   endtask

   task automatic pulseReset();
      rst_n = 1'b0;
      applyStimulus(2'b11);
      applyStimulus(2'b11);
      rst_n = 1'b1;
   endtask

   logic [NPADS-1:0] raw;
   logic [NPADS-1:0] prevToggle;
   int               runLeft [NPADS];
   int               pressCount;
   int               longCount;

   initial begin
      // Reset with both pads touched: everything stays quiet until release.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(2'b00);
         checkOutput("rst_outputs", pad_level | pad_press | pad_release | pad_toggle | pad_long, 2'b00);
      end
      rst_n = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         applyStimulus(2'b00);
         checkOutput("s1_press_edge", pad_press, (e == 7) ? 2'b11 : 2'b00);
      end
      checkOutput("s1_toggle", pad_toggle, 2'b11);
      checkOutput("s1_level", pad_level, 2'b11);
      for (int i = 0; i < 12; i++) applyStimulus(2'b11);
      checkOutput("s1_released", pad_level, 2'b00);

      // Short glitch on pad0.
      for (int i = 0; i < 13; i++) begin
         applyStimulus((i < 3) ? 2'b10 : 2'b11);
         checkOutput("s2_no_press", pad_press & 2'b01, 2'b00);
         checkOutput("s2_level", pad_level & 2'b01, 2'b00);
      end

      // Release bounce on pad0 is absorbed.
      for (int i = 0; i < 8; i++) applyStimulus(2'b10);
      checkOutput("s3_pressed", pad_level & 2'b01, 2'b01);
      for (int i = 0; i < 10; i++) begin
         applyStimulus((i < 2) ? 2'b11 : 2'b10);
         checkOutput("s3_no_release", pad_release & 2'b01, 2'b00);
         checkOutput("s3_level", pad_level & 2'b01, 2'b01);
      end
      for (int i = 0; i < 12; i++) applyStimulus(2'b11);

      // Three clean presses on pad1 from a fresh toggle state.
      pulseReset();
      pressCount = 0;
      prevToggle = pad_toggle;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 16; i++) begin
            applyStimulus((i < 8) ? 2'b01 : 2'b11);
            if (pad_press[1]) begin
               pressCount++;
               checkOutput("s4_toggle_value", pad_toggle & 2'b10, (k % 2 == 0) ? 2'b10 : 2'b00);
            end
            if (pad_toggle[1] != prevToggle[1])
               checkOutput("s4_toggle_with_press", pad_press & 2'b10, 2'b10);
            prevToggle = pad_toggle;
         end
      end
      checkOutput("s4_press_count", 2'(pressCount), 2'd3);

      // Reset during PRESS_WAIT discards the pending press.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(2'b10);
         checkOutput("s5_pre_reset", pad_press, 2'b00);
      end
      rst_n = 1'b0;
      applyStimulus(2'b10);
      applyStimulus(2'b10);
      rst_n = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         applyStimulus(2'b10);
         checkOutput("s5_press_edge", pad_press & 2'b01, (e == 7) ? 2'b01 : 2'b00);
      end
      checkOutput("s5_toggle", pad_toggle & 2'b01, 2'b01);

      // Keep holding pad0 past the long-press threshold.
      longCount = 0;
      for (int k = 1; k <= 30; k++) begin
         applyStimulus(2'b10);
         if (pad_long[0]) longCount++;
`ifdef TOUCH_PAD_LONG_PRESS_EN
         checkOutput("s6_long_edge", pad_long & 2'b01, (k == 16) ? 2'b01 : 2'b00);
`else
         checkOutput("s6_long_off", pad_long, 2'b00);
`endif
      end
`ifdef TOUCH_PAD_LONG_PRESS_EN
      checkOutput("s6_long_count", 2'(longCount), 2'd1);
      checkOutput("s6_toggle_cleared", pad_toggle & 2'b01, 2'b00);
`else
      checkOutput("s6_long_count", 2'(longCount), 2'd0);
      checkOutput("s6_toggle_kept", pad_toggle & 2'b01, 2'b01);
`endif
      for (int i = 0; i < 12; i++) applyStimulus(2'b11);

      // Random pad activity: mixes glitches, bounces, clean and long holds.
      raw = 2'b11;
      for (int p = 0; p < NPADS; p++) runLeft[p] = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int p = 0; p < NPADS; p++) begin
            if (runLeft[p] == 0) begin
               raw[p] = ~raw[p];
               runLeft[p] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 40))
                                                        : int'($urandom_range(1, 8));
            end
            runLeft[p]--;
         end
         rst_n = ($urandom_range(0, 499) != 0);
         applyStimulus(raw);
         rst_n = 1'b1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
